// File: rtl/ci_initiator_pkg.sv
// Shared types and widths for the custom-instruction initiator.
package ci_initiator_pkg;

  localparam int CI_DATA_W = 32;
  localparam int CI_ID_W   = 8;
  // One queued command: selector plus both operands.
  localparam int CI_CMD_W  = CI_ID_W + 2 * CI_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ci_state_e;

  typedef struct packed {
    logic [CI_ID_W-1:0]   ci_n;
    logic [CI_DATA_W-1:0] a;
    logic [CI_DATA_W-1:0] b;
  } ci_cmd_t;

endpackage

// File: rtl/ci_initiator_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, full/empty from a registered count.
module ci_initiator_cmd_fifo
  import ci_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [CI_CMD_W-1:0] wdata_i,
  output logic [CI_CMD_W-1:0] rdata_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CI_CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ci_initiator.sv
// Custom-instruction initiator: queues host commands, issues them one at a
// time to a responder, and holds each result (or a timeout) for the host.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight; pops the FIFO head when one is queued
// ST_ISSUE | single cycle, ciStart high; a same-cycle ciDone is taken
// ST_WAIT  | waiting for ciDone, timeout counter running
// ST_RESP  | rspValid high until the host takes it with rspReady
module ci_initiator
  import ci_initiator_pkg::*;
#(
  parameter logic [CI_ID_W-1:0] CUSTOM_ID      = 8'h01,
  parameter logic [15:0]        TIMEOUT_CYCLES = 16'd1000,
  parameter int                 FIFO_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [CI_ID_W-1:0]   cmdCiN,
  input  logic [CI_DATA_W-1:0] cmdA,
  input  logic [CI_DATA_W-1:0] cmdB,
  output logic                 ciStart,
  output logic [CI_ID_W-1:0]   ciN,
  output logic [CI_DATA_W-1:0] ciValueA,
  output logic [CI_DATA_W-1:0] ciValueB,
  input  logic                 ciDone,
  input  logic [CI_DATA_W-1:0] ciResult,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [CI_DATA_W-1:0] rspResult,
  output logic                 rspTimeout,
  output logic                 busy,
  output logic [15:0]          idHits
);

  ci_state_e            state_q, state_d;
  logic [CI_ID_W-1:0]   ci_n_q, ci_n_d;
  logic [CI_DATA_W-1:0] ci_a_q, ci_a_d;
  logic [CI_DATA_W-1:0] ci_b_q, ci_b_d;
  logic [CI_DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [15:0]          to_cnt_q, to_cnt_d;
  logic [15:0]          id_hits_q, id_hits_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CI_CMD_W-1:0]  fifo_rdata;
  ci_cmd_t              head;
  logic                 to_last;

  ci_initiator_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (cmdValid),
    .pop_i   (fifo_pop),
    .wdata_i ({cmdCiN, cmdA, cmdB}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head       = fifo_rdata;
  // Counter holds the number of completed WAIT cycles, so the last allowed one is TIMEOUT_CYCLES-1.
  assign to_last    = (to_cnt_q == TIMEOUT_CYCLES - 16'd1);

  assign cmdReady   = !fifo_full;
  assign ciStart    = (state_q == ST_ISSUE);
  assign ciN        = ci_n_q;
  assign ciValueA   = ci_a_q;
  assign ciValueB   = ci_b_q;
  assign rspValid   = (state_q == ST_RESP);
  assign rspResult  = rsp_result_q;
  assign rspTimeout = rsp_timeout_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign idHits     = id_hits_q;

  // Next-state, operand latch, response capture and hit counting.
  always_comb begin
    state_d       = state_q;
    ci_n_d        = ci_n_q;
    ci_a_d        = ci_a_q;
    ci_b_d        = ci_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    to_cnt_d      = to_cnt_q;
    id_hits_d     = id_hits_q;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          ci_n_d   = head.ci_n;
          ci_a_d   = head.a;
          ci_b_d   = head.b;
          to_cnt_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ci_n_q == CUSTOM_ID && id_hits_q != 16'hFFFF) id_hits_d = id_hits_q + 16'd1;
        if (ciDone) begin
          rsp_result_d  = ciResult;
          rsp_timeout_d = 1'b0;
          ci_n_d        = '0;
          ci_a_d        = '0;
          ci_b_d        = '0;
          state_d       = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ciDone) begin
          rsp_result_d  = ciResult;
          rsp_timeout_d = 1'b0;
          ci_n_d        = '0;
          ci_a_d        = '0;
          ci_b_d        = '0;
          to_cnt_d      = '0;
          state_d       = ST_RESP;
        end else if (to_last) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          ci_n_d        = '0;
          ci_a_d        = '0;
          ci_b_d        = '0;
          to_cnt_d      = '0;
          state_d       = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rspReady) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ci_n_q        <= '0;
      ci_a_q        <= '0;
      ci_b_q        <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      to_cnt_q      <= '0;
      id_hits_q     <= '0;
    end else begin
      state_q       <= state_d;
      ci_n_q        <= ci_n_d;
      ci_a_q        <= ci_a_d;
      ci_b_q        <= ci_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      to_cnt_q      <= to_cnt_d;
      id_hits_q     <= id_hits_d;
    end
  end

endmodule
